// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: active-low segment
// patterns ({g,f,e,d,c,b,a}) and lamp bit positions of the yellow lamps.
package seg_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam int YLW_MAIN   = 3;
  localparam int YLW_BRANCH = 0;

endpackage

// File: rtl/seg_scan_driver_bcd7seg.sv
// Combinational BCD to active-low seven-segment decode; non-decimal codes
// show a dash so a corrupted countdown is visible rather than silently wrong.
module bcd7seg
  import seg_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Two-digit multiplexed seven-segment driver with input synchronizer,
// frame-aligned snapshot, dead time per slot and yellow-lamp blinking.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD         = 2,
  parameter int BLINK_FRAMES = 250,
  parameter int LZB          = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] num0,
  input  logic [3:0] num1,
  input  logic [5:0] LEDR,
  output logic [6:0] seg,
  output logic [1:0] dig
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SLOT_LIGHT = SW'(DEAD - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [13:0]   w_in;
  logic [13:0]   r_sync1, r_sync2, r_prev;
  logic [SW-1:0] r_slot;
  logic          r_idx;
  logic [FW-1:0] r_frame;
  logic          r_phase;
  logic [3:0]    r_num0_s, r_num1_s;
  logic          r_ylw_s;

  logic          w_stable, w_slot_wrap, w_frame_start, w_load;
  logic          w_ylw_in, w_ylw_rise, w_blank;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg;

  assign w_in          = {LEDR, num1, num0};
  assign w_stable      = (r_sync2 == r_prev);
  assign w_slot_wrap   = (r_slot == SLOT_LAST);
  assign w_frame_start = w_slot_wrap && r_idx;
  assign w_load        = w_frame_start && w_stable;
  assign w_ylw_in      = r_sync2[8 + YLW_MAIN] | r_sync2[8 + YLW_BRANCH];
  assign w_ylw_rise    = w_load && w_ylw_in && !r_ylw_s;

  // Snapshot and phase are frame-constant, so every slot of a frame agrees.
  assign w_digit = r_idx ? r_num1_s : r_num0_s;
  assign w_blank = ((LZB != 0) && r_idx && (r_num1_s == 4'd0)) || (r_ylw_s && !r_phase);

  bcd7seg u_dec (
    .i_bcd (w_digit),
    .o_seg (w_seg)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_prev   <= '0;
      r_num0_s <= 4'd0;
      r_num1_s <= 4'd0;
      r_ylw_s  <= 1'b0;
    end else begin
      r_sync1 <= w_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (w_load) begin
        r_num0_s <= r_sync2[3:0];
        r_num1_s <= r_sync2[7:4];
        r_ylw_s  <= w_ylw_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot <= '0;
      r_idx  <= 1'b0;
    end else if (w_slot_wrap) begin
      r_slot <= '0;
      r_idx  <= ~r_idx;
    end else begin
      r_slot <= r_slot + SW'(1);
    end
  end

  // A fresh yellow snapshot restarts the blink so it always opens lit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame <= '0;
      r_phase <= 1'b1;
    end else if (w_ylw_rise) begin
      r_frame <= '0;
      r_phase <= 1'b1;
    end else if (w_frame_start) begin
      if (r_frame == FRAME_LAST) begin
        r_frame <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_frame <= r_frame + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= SEG_OFF;
      dig <= 2'b11;
    end else if (w_slot_wrap) begin
      seg <= SEG_OFF;
      dig <= 2'b11;
    end else if (r_slot == SLOT_LIGHT) begin
      if (w_blank) begin
        seg <= SEG_OFF;
        dig <= 2'b11;
      end else begin
        seg <= w_seg;
        dig <= r_idx ? 2'b01 : 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=8, DEAD=2, BLINK_FRAMES=4.
module tb_seg_scan_driver;

  localparam logic [6:0] T_SEG0 = 7'h40;
  localparam logic [6:0] T_SEG3 = 7'h30;
  localparam logic [6:0] T_SEG6 = 7'h02;
  localparam logic [6:0] T_SEG9 = 7'h10;
  localparam logic [6:0] T_DASH = 7'h3F;
  localparam logic [6:0] T_OFF  = 7'h7F;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] num0, num1;
  logic [5:0] LEDR;
  logic [6:0] seg;
  logic [1:0] dig;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .SCAN_DIV     (8),
    .DEAD         (2),
    .BLINK_FRAMES (4),
    .LZB          (1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .num0 (num0),
    .num1 (num1),
    .LEDR (LEDR),
    .seg  (seg),
    .dig  (dig)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One clock; expected outputs follow from the bench's own cycle count.
  task automatic step(input string tag, input logic [6:0] u_seg, input bit u_lit,
                      input logic [6:0] t_seg, input bit t_lit);
    int slot;
    int idx;
    logic [6:0] es;
    logic [1:0] ed;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    slot = cyc % 8;
    idx  = (cyc / 8) % 2;
    es = T_OFF;
    ed = 2'b11;
    if (slot >= 2) begin
      if (idx == 0 && u_lit) begin
        es = u_seg;
        ed = 2'b10;
      end else if (idx == 1 && t_lit) begin
        es = t_seg;
        ed = 2'b01;
      end
    end
    check($sformatf("%s c%0d seg", tag, cyc), {25'd0, seg}, {25'd0, es});
    check($sformatf("%s c%0d dig", tag, cyc), {30'd0, dig}, {30'd0, ed});
  endtask

  task automatic frame(input string tag, input logic [6:0] u_seg, input bit u_lit,
                       input logic [6:0] t_seg, input bit t_lit, input bit tog);
    for (int i = 0; i < 16; i++) begin
      step(tag, u_seg, u_lit, t_seg, t_lit);
      if (tog) num0 = (num0 == 4'd5) ? 4'd7 : 4'd5;
    end
    $display("frame %s: units %h lit=%0d tens %h lit=%0d  (cycle %0d, %0d checks so far)",
             tag, u_seg, u_lit, t_seg, t_lit, cyc, n_checks);
  endtask

  initial begin
    rst  = 1'b1;
    num0 = 4'd0;
    num1 = 4'd6;
    LEDR = 6'b010100;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset seg", {25'd0, seg}, {25'd0, T_OFF});
    check("reset dig", {30'd0, dig}, {30'd0, 2'b11});
    rst = 1'b1;
    cyc = 0;

    // Before the first snapshot the reset snapshot (00) is shown.
    frame("t1 f0", T_SEG0, 1, T_SEG6, 0, 0);
    frame("t1 f1", T_SEG0, 1, T_SEG6, 1, 0);

    // Yellow: blink 4 on / 4 off starting lit, tens blanked as leading zero.
    num1 = 4'd0;
    num0 = 4'd3;
    LEDR = 6'b001100;
    frame("t2 trans", T_SEG0, 1, T_SEG6, 1, 0);
    for (int f = 0; f < 13; f++)
      frame($sformatf("t2 blink%0d", f), T_SEG3, ((f / 4) % 2) == 0, T_SEG0, 0, 0);

    // Yellow to red while phase is off: one dark frame, then lit at once.
    LEDR = 6'b100010;
    frame("t6 trans", T_SEG3, 0, T_SEG0, 0, 0);
    frame("t6 red", T_SEG3, 1, T_SEG0, 0, 0);

    num0 = 4'hB;
    frame("t3 trans", T_SEG3, 1, T_SEG0, 0, 0);
    frame("t3 dash", T_DASH, 1, T_SEG0, 0, 0);

    // Input toggling across a frame boundary must not reach the snapshot.
    num0 = 4'd5;
    frame("t4 toggle", T_DASH, 1, T_SEG0, 0, 1);
    num0 = 4'd9;
    frame("t4 hold", T_DASH, 1, T_SEG0, 0, 0);
    frame("t4 new", T_SEG9, 1, T_SEG0, 0, 0);

    // Asynchronous reset in the middle of a lit units slot.
    for (int i = 0; i < 4; i++) step("t5 pre", T_SEG9, 1, T_SEG0, 0);
    #2 rst = 1'b0;
    #1;
    check("t5 async seg", {25'd0, seg}, {25'd0, T_OFF});
    check("t5 async dig", {30'd0, dig}, {30'd0, 2'b11});
    repeat (2) @(negedge clk);
    check("t5 held seg", {25'd0, seg}, {25'd0, T_OFF});
    check("t5 held dig", {30'd0, dig}, {30'd0, 2'b11});
    rst = 1'b1;
    cyc = 0;
    frame("t5 f0", T_SEG0, 1, T_SEG0, 0, 0);
    frame("t5 f1", T_SEG9, 1, T_SEG0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
